// File: rtl/demux_32_one_two_buffered.sv
// One-to-two demultiplexer: a single producer stream is steered by select
// into one of two small FIFOs, each drained by its own valid/ready consumer.
module demux_32_one_two_buffered #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       select,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           data_out_0,
  output logic                       valid_out_0,
  input  logic                       ready_out_0,
  output logic [WIDTH-1:0]           data_out_1,
  output logic                       valid_out_1,
  input  logic                       ready_out_1,
  output logic [$clog2(DEPTH):0]     count_0,
  output logic [$clog2(DEPTH):0]     count_1
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned NCH = 2;

  logic [WIDTH-1:0] mem_q  [NCH][DEPTH];
  logic [AW-1:0]    wptr_q [NCH];
  logic [AW-1:0]    wptr_d [NCH];
  logic [AW-1:0]    rptr_q [NCH];
  logic [AW-1:0]    rptr_d [NCH];
  logic [CW-1:0]    cnt_q  [NCH];
  logic [CW-1:0]    cnt_d  [NCH];
  logic [NCH-1:0]   push;
  logic [NCH-1:0]   pop;
  logic [NCH-1:0]   rdy_out;

  // Acceptance looks only at the selected channel's occupancy, never at its pop.
  assign in_ready = reset_n & (cnt_q[select] < CW'(DEPTH));

  assign rdy_out = {ready_out_1, ready_out_0};
  assign push    = {in_valid & in_ready & select, in_valid & in_ready & ~select};

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      pop[k]    = (cnt_q[k] != '0) & rdy_out[k];
      wptr_d[k] = wptr_q[k];
      rptr_d[k] = rptr_q[k];
      cnt_d[k]  = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
      if (push[k]) wptr_d[k] = wptr_q[k] + AW'(1);
      if (pop[k])  rptr_d[k] = rptr_q[k] + AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
        cnt_q[k]  <= '0;
        for (int e = 0; e < DEPTH; e++) mem_q[k][e] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (push[k]) mem_q[k][wptr_q[k]] <= data_in;
        wptr_q[k] <= wptr_d[k];
        rptr_q[k] <= rptr_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  assign data_out_0  = mem_q[0][rptr_q[0]];
  assign data_out_1  = mem_q[1][rptr_q[1]];
  assign valid_out_0 = (cnt_q[0] != '0);
  assign valid_out_1 = (cnt_q[1] != '0);
  assign count_0     = cnt_q[0];
  assign count_1     = cnt_q[1];

endmodule

// File: tb/tb_demux_32_one_two_buffered.sv
// Directed bench for demux_32_one_two_buffered with hand-computed expectations.
module tb_demux_32_one_two_buffered;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] data_in;
  logic        select;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_out_0;
  logic        valid_out_0;
  logic        ready_out_0;
  logic [31:0] data_out_1;
  logic        valid_out_1;
  logic        ready_out_1;
  logic [1:0]  count_0;
  logic [1:0]  count_1;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  demux_32_one_two_buffered #(.DEPTH(2), .WIDTH(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .data_in     (data_in),
    .select      (select),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_out_0  (data_out_0),
    .valid_out_0 (valid_out_0),
    .ready_out_0 (ready_out_0),
    .data_out_1  (data_out_1),
    .valid_out_1 (valid_out_1),
    .ready_out_1 (ready_out_1),
    .count_0     (count_0),
    .count_1     (count_1)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_n = 1'b0; data_in = '0; select = 1'b0; in_valid = 1'b0;
    ready_out_0 = 1'b0; ready_out_1 = 1'b0;

    // reset held for two cycles
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("rst_in_ready2", 32'(in_ready), 32'd0);
    check("rst_cnt0", 32'(count_0), 32'd0);
    check("rst_cnt1", 32'(count_1), 32'd0);
    check("rst_vld0", 32'(valid_out_0), 32'd0);
    check("rst_vld1", 32'(valid_out_1), 32'd0);
    check("rst_dat0", data_out_0, 32'h0);
    check("rst_dat1", data_out_1, 32'h0);
    reset_n = 1'b1;
    settle();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // single word through channel 0
    data_in = 32'hDEADBEEF; select = 1'b0; in_valid = 1'b1; ready_out_0 = 1'b1;
    tick();
    in_valid = 1'b0;
    settle();
    check("p1_vld0", 32'(valid_out_0), 32'd1);
    check("p1_dat0", data_out_0, 32'hDEADBEEF);
    check("p1_cnt0", 32'(count_0), 32'd1);
    check("p1_vld1", 32'(valid_out_1), 32'd0);
    check("p1_cnt1", 32'(count_1), 32'd0);
    tick();
    check("p1_cnt0_after", 32'(count_0), 32'd0);
    check("p1_vld0_after", 32'(valid_out_0), 32'd0);

    // fill channel 1 while it stalls
    ready_out_0 = 1'b0; ready_out_1 = 1'b0;
    select = 1'b1; in_valid = 1'b1; data_in = 32'h11111111;
    tick();
    data_in = 32'h22222222;
    tick();
    in_valid = 1'b0;
    settle();
    check("fill_cnt1", 32'(count_1), 32'd2);
    check("fill_rdy_sel1", 32'(in_ready), 32'd0);
    check("fill_head1", data_out_1, 32'h11111111);
    select = 1'b0;
    settle();
    check("fill_rdy_sel0", 32'(in_ready), 32'd1);

    // full channel rejects a push even while popping
    select = 1'b1; in_valid = 1'b1; data_in = 32'h0BAD0BAD; ready_out_1 = 1'b1;
    settle();
    check("full_reject_rdy", 32'(in_ready), 32'd0);
    tick();
    check("pop1_cnt1", 32'(count_1), 32'd1);
    check("pop1_head1", data_out_1, 32'h22222222);

    // push across the pointer wrap
    ready_out_1 = 1'b0; data_in = 32'h33333333;
    tick();
    in_valid = 1'b0;
    settle();
    check("wrap_cnt1", 32'(count_1), 32'd2);
    check("wrap_head1", data_out_1, 32'h22222222);
    ready_out_1 = 1'b1;
    tick();
    ready_out_1 = 1'b0;
    settle();
    check("wrap_head1_next", data_out_1, 32'h33333333);
    check("wrap_cnt1_next", 32'(count_1), 32'd1);

    // simultaneous push/pop on ch0, independent pop on ch1
    select = 1'b0; in_valid = 1'b1; data_in = 32'hA0A0A0A0;
    tick();
    check("pp_cnt0_pre", 32'(count_0), 32'd1);
    check("pp_head0_pre", data_out_0, 32'hA0A0A0A0);
    data_in = 32'hB0B0B0B0; ready_out_0 = 1'b1; ready_out_1 = 1'b1;
    tick();
    in_valid = 1'b0; ready_out_0 = 1'b0; ready_out_1 = 1'b0;
    settle();
    check("pp_cnt0", 32'(count_0), 32'd1);
    check("pp_head0", data_out_0, 32'hB0B0B0B0);
    check("pp_cnt1", 32'(count_1), 32'd0);
    check("pp_vld1", 32'(valid_out_1), 32'd0);

    // stall stability on channel 0
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_dat0", data_out_0, 32'hB0B0B0B0);
      check("stall_vld0", 32'(valid_out_0), 32'd1);
    end

    // load both channels to two words, then reset mid-stream
    select = 1'b0; in_valid = 1'b1; data_in = 32'hC0C0C0C0;
    tick();
    select = 1'b1; data_in = 32'hD1D1D1D1;
    tick();
    data_in = 32'hE1E1E1E1;
    tick();
    in_valid = 1'b0;
    settle();
    check("pre_rst_cnt0", 32'(count_0), 32'd2);
    check("pre_rst_cnt1", 32'(count_1), 32'd2);
    reset_n = 1'b0;
    settle();
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset_n = 1'b1;
    settle();
    check("mid_rst_cnt0", 32'(count_0), 32'd0);
    check("mid_rst_cnt1", 32'(count_1), 32'd0);
    check("mid_rst_vld0", 32'(valid_out_0), 32'd0);
    check("mid_rst_vld1", 32'(valid_out_1), 32'd0);
    check("mid_rst_dat0", data_out_0, 32'h0);
    check("mid_rst_dat1", data_out_1, 32'h0);
    ready_out_0 = 1'b1; ready_out_1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_stale_vld0", 32'(valid_out_0), 32'd0);
      check("no_stale_vld1", 32'(valid_out_1), 32'd0);
    end

    // operation resumes after reset
    ready_out_1 = 1'b0; select = 1'b1; in_valid = 1'b1; data_in = 32'hF00DF00D;
    tick();
    in_valid = 1'b0;
    settle();
    check("resume_dat1", data_out_1, 32'hF00DF00D);
    check("resume_cnt1", 32'(count_1), 32'd1);
    check("resume_vld0", 32'(valid_out_0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/demux_32_one_two_buffered.md
Name: demux_32_one_two_buffered

Overview:
- 32-bit one-to-two demultiplexer with per-output buffering. It is the inverse of the two-to-one datapath mux.
- One producer stream is steered by `select` to one of two consumers.
- Each consumer side has a small FIFO and its own valid/ready handshake.
- Used where a single result bus must be routed to two independent sinks that may stall, e.g. writeback vs. store path.

Parameters:
- DEPTH, 2, entries per output channel FIFO; power of two, minimum 2
- WIDTH, 32, data width in bits

Ports:
- clock  input  1  single system clock; all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- data_in  input  WIDTH  incoming data word
- select  input  1  destination channel: 0 = channel 0, 1 = channel 1
- in_valid  input  1  producer has a word on data_in/select
- in_ready  output  1  selected channel can accept a word this cycle
- data_out_0  output  WIDTH  head entry of channel 0 FIFO
- valid_out_0  output  1  channel 0 FIFO non-empty
- ready_out_0  input  1  channel 0 consumer accepts head this cycle
- data_out_1  output  WIDTH  head entry of channel 1 FIFO
- valid_out_1  output  1  channel 1 FIFO non-empty
- ready_out_1  input  1  channel 1 consumer accepts head this cycle
- count_0  output  clog2(DEPTH)+1  channel 0 occupancy
- count_1  output  clog2(DEPTH)+1  channel 1 occupancy

Behaviour:
- Clocking/reset: one clock. Reset is synchronous and active-low; sampled on the rising edge of clock while reset_n = 0.
- Reset state:
  - count_0 = count_1 = 0 and all read/write pointers = 0.
  - valid_out_0 = valid_out_1 = 0.
  - data_out_0 = data_out_1 = 0; storage is cleared.
  - in_ready is forced to 0 while reset_n = 0.
- Reset mid-operation: all buffered words in both channels are discarded with no output handshake. Operation resumes on the first cycle after reset_n returns to 1.
- in_ready is combinational:
  - in_ready = (count_sel < DEPTH), where count_sel is the occupancy of the channel named by `select`.
  - It does not depend on ready_out_k. A full channel rejects a push even when it is popping in the same cycle.
- select is meaningful only when in_valid = 1; it may toggle freely otherwise.
- Push: when in_valid & in_ready at the edge, data_in is written at the selected channel's write pointer; that pointer increments modulo DEPTH.
- Pop, per channel k: when valid_out_k & ready_out_k at the edge, that channel's read pointer increments modulo DEPTH.
- Occupancy update, per channel: count_k(next) = count_k + push_k - pop_k.
  - A simultaneous push and pop on the same channel leaves count unchanged and preserves order.
- Both channels pop independently in the same cycle. A push to one channel never affects the other.
- valid_out_k = (count_k != 0); data_out_k = storage[read pointer k].
  - Outputs are registered/stored. There is no combinational fall-through from data_in.
- Latency: a word pushed at edge N appears on data_out_k with valid_out_k = 1 in the cycle after edge N, if the channel was empty.
- Output stability: while valid_out_k = 1 and ready_out_k = 0, data_out_k and valid_out_k are held.
- Per-channel ordering is FIFO. No ordering is guaranteed between channels.
- Empty pop: ready_out_k with valid_out_k = 0 is ignored; count_k does not underflow.
- Full: count_k = DEPTH means no further pushes to k. Pushes to the other channel remain accepted.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no loss or duplication.
- Out-of-range data is not possible; WIDTH bits pass unmodified, with no sign or zero manipulation.

Test Plan:
- Reset then idle, with reset_n = 0 for 2 cycles -> all valid_out = 0, data_out = 0, counts = 0, in_ready = 0 during reset and 1 after.
- Push 0xDEADBEEF with select = 0, ready_out_0 = 1 -> next cycle valid_out_0 = 1 and data_out_0 = 0xDEADBEEF. The following cycle count_0 = 0. Channel 1 is untouched.
- Fill and wrap channel 1 with ready_out_1 = 0:
  - Push 0x11111111 and 0x22222222 -> count_1 = 2; in_ready = 0 when select = 1 and 1 when select = 0.
  - Then pop one and push 0x33333333 -> outputs appear in order 0x11111111, 0x22222222, 0x33333333 across the pointer wrap.
- Simultaneous push/pop on channel 0 at count_0 = 1 -> count_0 stays 1 and the order is preserved. Meanwhile channel 1 pops its head in the same cycle -> count_1 decrements.
- Stall stability: hold ready_out_0 = 0 for 5 cycles with valid_out_0 = 1 -> data_out_0 stays constant.
- Reset mid-stream: pulse reset_n = 0 for 1 cycle with both channels holding 2 words -> counts = 0, valid_out = 0, and no stale word appears afterwards.
